rgb_ball_seq_gen: RTL

Stimulus-side companion to the RGB ball sequence detector. It emits a stream of 2-bit ball colour codes, one per clock, built from repeated three-ball permutations of {G, B, R}. It drives the detector's colour input in system tests and on the demo board, so detection behaviour can be exercised with known, repeatable sequences. A start/busy/done handshake controls it, with a one-cycle error flag for illegal requests.

---
 rtl/rgb_ball_pkg.sv | 38 +++
 rtl/rgb_ball_seq_gen_if.sv | 18 +
 rtl/rgb_ball_seq_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/rgb_ball_pkg.sv
// Shared definitions for the RGB ball generator and detector: colour codes,
// generator FSM encoding and the permutation lookup.
package rgb_ball_pkg;

  localparam logic [1:0] GC = 2'b00;
  localparam logic [1:0] BC = 2'b01;
  localparam logic [1:0] RC = 2'b10;
  localparam logic [1:0] NC = 2'b11;

  localparam logic [2:0] PERM_MAX = 3'd5;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  // Index -> ball order: 0 GBR, 1 GRB, 2 BGR, 3 BRG, 4 RGB, 5 RBG.
  function automatic logic [1:0] perm_color(input logic [2:0] p, input logic [1:0] pos);
    logic [5:0] order;
    order = {NC, NC, NC};
    case (p)
      3'd0:    order = {GC, BC, RC};
      3'd1:    order = {GC, RC, BC};
      3'd2:    order = {BC, GC, RC};
      3'd3:    order = {BC, RC, GC};
      3'd4:    order = {RC, GC, BC};
      3'd5:    order = {RC, BC, GC};
      default: order = {NC, NC, NC};
    endcase
    case (pos)
      2'd0:    return order[5:4];
      2'd1:    return order[3:2];
      default: return order[1:0];
    endcase
  endfunction

  function automatic logic [2:0] next_perm(input logic [2:0] p);
    return (p >= PERM_MAX) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_ball_seq_gen_if.sv
// Control handshake and colour stream between a test controller (master)
// and the ball sequence generator (slave).
interface rgb_ball_seq_gen_if #(parameter int REP_W = 4);
  logic             start;
  logic [2:0]       perm;
  logic [REP_W-1:0] nrep;
  logic             rot;
  logic [1:0]       col;
  logic             col_vld;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, perm, nrep, rot,
                  input  col, col_vld, busy, done, err);
  modport slave  (input  start, perm, nrep, rot,
                  output col, col_vld, busy, done, err);
endinterface

// File: rtl/rgb_ball_seq_gen.sv
// Emits nrep triples of ball colours from a permutation table, one ball per
// clock, optionally rotating the permutation after every triple.
module rgb_ball_seq_gen
  import rgb_ball_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  rgb_ball_seq_gen_if.slave bus
);

  state_t           state, state_nx;
  logic [2:0]       cur_perm, cur_perm_nx;
  logic [REP_W-1:0] rep_left, rep_left_nx;
  logic [1:0]       col_nx;
  logic             vld_nx, busy_nx, done_nx, err_nx;

  // Outputs are computed for the next state so they can be registered and
  // still show the first ball in the cycle right after start is sampled.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    state_nx    = state;
    cur_perm_nx = cur_perm;
    rep_left_nx = rep_left;
    col_nx      = NC;
    vld_nx      = 1'b0;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.perm > PERM_MAX) begin
            err_nx = 1'b1;
          end else if (bus.nrep == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx    = B0;
            cur_perm_nx = bus.perm;
            rep_left_nx = bus.nrep;
            col_nx      = perm_color(bus.perm, 2'd0);
            vld_nx      = 1'b1;
            busy_nx     = 1'b1;
          end
        end
      end
      B0: begin
        state_nx = B1;
        col_nx   = perm_color(cur_perm, 2'd1);
        vld_nx   = 1'b1;
        busy_nx  = 1'b1;
      end
      B1: begin
        state_nx = B2;
        col_nx   = perm_color(cur_perm, 2'd2);
        vld_nx   = 1'b1;
        busy_nx  = 1'b1;
      end
      B2: begin
        rep_left_nx = rep_left - 1'b1;
        if (bus.rot) cur_perm_nx = next_perm(cur_perm);
        if (rep_left == REP_W'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = B0;
          col_nx   = perm_color(cur_perm_nx, 2'd0);
          vld_nx   = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_perm    <= 3'd0;
      rep_left    <= '0;
      bus.col     <= NC;
      bus.col_vld <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state       <= state_nx;
      cur_perm    <= cur_perm_nx;
      rep_left    <= rep_left_nx;
      bus.col     <= col_nx;
      bus.col_vld <= vld_nx;
      bus.busy    <= busy_nx;
      bus.done    <= done_nx;
      bus.err     <= err_nx;
    end
  end

endmodule
